// File: rtl/pwm_update_scheduler_pkg.sv
// Shared definitions for the PWM update scheduler: CTRL layout, FSM encoding
// and the ramp helper used by the per-channel commit logic.
package pwm_update_scheduler_pkg;

    localparam int unsigned RampEnBit = 0;
    localparam int unsigned HoldBit   = 1;

    typedef enum logic [0:0] {
        StRun    = 1'b0,
        StCommit = 1'b1
    } state_e;

    // CTRL sits directly above the last channel's shadow register.
    function automatic logic [2:0] ctrl_addr(input int unsigned nch);
        return 3'(nch);
    endfunction

    // Move cur toward tgt by at most step; never overshoots and never wraps.
    function automatic logic [31:0] ramp_toward(input logic [31:0] cur,
                                                input logic [31:0] tgt,
                                                input logic [31:0] step);
        if (tgt > cur) begin
            return (tgt - cur > step) ? cur + step : tgt;
        end
        return (cur - tgt > step) ? cur - step : tgt;
    endfunction

endpackage

// File: rtl/pwm_update_scheduler_timer.sv
// Shared prescaler and period counter: one counter tick every N+1 clocks,
// period of 2^DW ticks, wrap flags the last clock of each period.
module pwm_period_timer #(
    parameter int unsigned DW = 8,
    parameter int unsigned N  = 31
) (
    input  logic          clk_i,
    input  logic          rst_i,
    output logic [DW-1:0] cnt_o,
    output logic          tick_o,
    output logic          wrap_o
);

    localparam int unsigned PW = (N > 0) ? $clog2(N + 1) : 1;

    logic [PW-1:0] pre_cnt_q, pre_cnt_d;
    logic [DW-1:0] cnt_q, cnt_d;

    always_comb begin
        tick_o    = (pre_cnt_q == PW'(N));
        wrap_o    = tick_o && (cnt_q == {DW{1'b1}});
        pre_cnt_d = tick_o ? '0 : pre_cnt_q + PW'(1);
        cnt_d     = tick_o ? cnt_q + DW'(1) : cnt_q;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            pre_cnt_q <= '0;
            cnt_q     <= '0;
        end else begin
            pre_cnt_q <= pre_cnt_d;
            cnt_q     <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/pwm_update_scheduler.sv
// Buffers duty writes in shadow registers and commits them to the active PWM
// duties only at period boundaries, optionally ramping one step per period.
module pwm_update_scheduler
    import pwm_update_scheduler_pkg::*;
#(
    parameter int unsigned NCH       = 4,
    parameter int unsigned DW        = 8,
    parameter int unsigned N         = 31,
    parameter int unsigned RAMP_STEP = 1
) (
    input  logic              CLK_IN,
    input  logic              RST,
    input  logic              WR_VALID,
    output logic              WR_READY,
    input  logic [2:0]        WR_ADDR,
    input  logic [DW-1:0]     WR_DATA,
    output logic              WR_ERR,
    output logic [NCH*DW-1:0] DUTY_BUS,
    output logic [NCH-1:0]    PWM_OUT,
    output logic              PERIOD_END,
    output logic              SETTLED
);

    localparam logic [2:0] CtrlAddr = ctrl_addr(NCH);

    logic [DW-1:0] cnt;
    logic          tick;
    logic          wrap;

    state_e                  state_q, state_d;
    logic                    live_q;
    logic [1:0]              ctrl_q, ctrl_d;
    logic [NCH-1:0][DW-1:0]  shadow_q, shadow_d;
    logic [NCH-1:0][DW-1:0]  active_q, active_d;
    logic [NCH-1:0][DW-1:0]  active_next;
    logic [NCH-1:0]          pwm_q, pwm_d;
    logic [NCH-1:0]          chan_settled;
    logic                    err_q, err_d;
    logic                    period_end_q;
    logic                    accept;

    pwm_period_timer #(
        .DW (DW),
        .N  (N)
    ) u_timer (
        .clk_i  (CLK_IN),
        .rst_i  (RST),
        .cnt_o  (cnt),
        .tick_o (tick),
        .wrap_o (wrap)
    );

    // Counter ticks are only needed inside the timer itself.
    logic unused_tick;
    assign unused_tick = tick;

    always_comb begin
        state_d  = state_q;
        ctrl_d   = ctrl_q;
        shadow_d = shadow_q;
        active_d = active_q;
        err_d    = 1'b0;

        // live_q keeps the port closed until the first cycle after reset.
        WR_READY = live_q && (state_q == StRun);
        accept   = WR_VALID && WR_READY;

        unique case (state_q)
            StRun: begin
                if (wrap && !ctrl_q[HoldBit]) begin
                    state_d = StCommit;
                end
            end
            StCommit: begin
                state_d  = StRun;
                active_d = active_next;
            end
            default: state_d = StRun;
        endcase

        if (accept) begin
            if (WR_ADDR == CtrlAddr) begin
                ctrl_d = WR_DATA[1:0];
            end else if (WR_ADDR > CtrlAddr) begin
                err_d = 1'b1;
            end else begin
                for (int unsigned i = 0; i < NCH; i++) begin
                    if (WR_ADDR == 3'(i)) begin
                        shadow_d[i] = WR_DATA;
                    end
                end
            end
        end
    end

    for (genvar i = 0; i < NCH; i++) begin : g_chan
        assign active_next[i] = ctrl_q[RampEnBit]
            ? DW'(ramp_toward(32'(active_q[i]), 32'(shadow_q[i]), 32'(RAMP_STEP)))
            : shadow_q[i];
        assign pwm_d[i]              = (cnt < active_q[i]);
        assign chan_settled[i]       = (active_q[i] == shadow_q[i]);
        assign DUTY_BUS[i*DW +: DW]  = active_q[i];
    end

    always_ff @(posedge CLK_IN) begin
        if (RST) begin
            state_q      <= StRun;
            live_q       <= 1'b0;
            ctrl_q       <= '0;
            shadow_q     <= '0;
            active_q     <= '0;
            pwm_q        <= '0;
            err_q        <= 1'b0;
            period_end_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            live_q       <= 1'b1;
            ctrl_q       <= ctrl_d;
            shadow_q     <= shadow_d;
            active_q     <= active_d;
            pwm_q        <= pwm_d;
            err_q        <= err_d;
            period_end_q <= wrap;
        end
    end

    assign PWM_OUT    = pwm_q;
    assign WR_ERR     = err_q;
    assign PERIOD_END = period_end_q;
    assign SETTLED    = &chan_settled;

endmodule

// File: tb/tb_pwm_update_scheduler.sv
// Self-checking bench for pwm_update_scheduler: directed sequences, a write
// table and random traffic, all compared against a period-arithmetic model.
module tb_pwm_update_scheduler;

    localparam int unsigned NCH       = 4;
    localparam int unsigned DW        = 8;
    localparam int unsigned N         = 1;
    localparam int unsigned RAMP_STEP = 1;
    localparam int unsigned PER       = (N + 1) * (1 << DW);

    logic              clk      = 1'b0;
    logic              rst      = 1'b1;
    logic              wr_valid = 1'b0;
    logic [2:0]        wr_addr  = '0;
    logic [DW-1:0]     wr_data  = '0;
    logic              wr_ready;
    logic              wr_err;
    logic [NCH*DW-1:0] duty_bus;
    logic [NCH-1:0]    pwm_out;
    logic              period_end;
    logic              settled;

    int checks = 0;
    int errors = 0;

    // Reference model: timer position is derived from mk, the number of
    // clock edges since reset released.
    int unsigned    mk       = 0;
    bit             m_live   = 1'b0;
    bit             m_commit = 1'b0;
    bit             m_pend   = 1'b0;
    bit             m_err    = 1'b0;
    int unsigned    m_ctrl   = 0;
    int unsigned    m_sh[NCH];
    int unsigned    m_act[NCH];
    bit [NCH-1:0]   m_pwm    = '0;

    typedef struct {
        logic [2:0]  addr;
        logic [7:0]  data;
        bit          exp_err;
        logic [31:0] exp_bus;
    } vec_t;

    vec_t vecs[8];

    pwm_update_scheduler #(
        .NCH       (NCH),
        .DW        (DW),
        .N         (N),
        .RAMP_STEP (RAMP_STEP)
    ) dut (
        .CLK_IN     (clk),
        .RST        (rst),
        .WR_VALID   (wr_valid),
        .WR_READY   (wr_ready),
        .WR_ADDR    (wr_addr),
        .WR_DATA    (wr_data),
        .WR_ERR     (wr_err),
        .DUTY_BUS   (duty_bus),
        .PWM_OUT    (pwm_out),
        .PERIOD_END (period_end),
        .SETTLED    (settled)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            if (errors <= 40) begin
                $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
            end
        end
    endtask

    function automatic int unsigned toward(int unsigned cur, int unsigned tgt);
        int unsigned diff;
        if (tgt >= cur) begin
            diff = tgt - cur;
            return cur + ((diff < RAMP_STEP) ? diff : RAMP_STEP);
        end
        diff = cur - tgt;
        return cur - ((diff < RAMP_STEP) ? diff : RAMP_STEP);
    endfunction

    // Advance the model across one rising edge using the inputs now driven.
    task automatic model_edge();
        int unsigned cnt_now;
        bit          wrap_now;
        bit          acc;
        bit          nxt_commit;
        if (rst) begin
            mk = 0; m_live = 0; m_commit = 0; m_pend = 0; m_err = 0; m_ctrl = 0; m_pwm = '0;
            for (int i = 0; i < NCH; i++) begin
                m_sh[i] = 0;
                m_act[i] = 0;
            end
            return;
        end
        cnt_now  = (mk / (N + 1)) % (1 << DW);
        wrap_now = (mk % PER) == PER - 1;
        acc      = wr_valid && m_live && !m_commit;
        for (int i = 0; i < NCH; i++) m_pwm[i] = cnt_now < m_act[i];
        if (m_commit) begin
            for (int i = 0; i < NCH; i++) begin
                m_act[i] = m_ctrl[0] ? toward(m_act[i], m_sh[i]) : m_sh[i];
            end
        end
        nxt_commit = !m_commit && wrap_now && !m_ctrl[1];
        m_err = acc && (wr_addr > 3'(NCH));
        if (acc) begin
            if (wr_addr < 3'(NCH)) m_sh[wr_addr] = wr_data;
            else if (wr_addr == 3'(NCH)) m_ctrl = wr_data & 8'h03;
        end
        m_pend   = wrap_now;
        m_commit = nxt_commit;
        m_live   = 1'b1;
        mk++;
    endtask

    task automatic model_compare();
        logic [NCH*DW-1:0] exp_bus;
        bit                exp_settled;
        exp_settled = 1'b1;
        for (int i = 0; i < NCH; i++) begin
            exp_bus[i*DW +: DW] = DW'(m_act[i]);
            if (m_act[i] != m_sh[i]) exp_settled = 1'b0;
        end
        chk("model duty_bus", 64'(duty_bus), 64'(exp_bus));
        chk("model pwm_out", 64'(pwm_out), 64'(m_pwm));
        chk("model period_end", 64'(period_end), 64'(m_pend));
        chk("model wr_err", 64'(wr_err), 64'(m_err));
        chk("model wr_ready", 64'(wr_ready), 64'(m_live && !m_commit));
        chk("model settled", 64'(settled), 64'(exp_settled));
    endtask

    task automatic step();
        model_edge();
        @(posedge clk);
        #1;
        model_compare();
    endtask

    task automatic do_write(input logic [2:0] a, input logic [7:0] d, output int waited);
        waited   = 0;
        wr_valid = 1'b1;
        wr_addr  = a;
        wr_data  = d;
        while (!wr_ready && waited < 4 * PER) begin
            step();
            waited++;
        end
        if (!wr_ready) begin
            checks++;
            errors++;
            $display("FAIL write_accept: wr_ready stayed low for %0d cycles, required high", waited);
        end else begin
            step();
        end
        wr_valid = 1'b0;
    endtask

    task automatic wait_period_end();
        int n = 0;
        do begin
            step();
            n++;
        end while (!period_end && n < 2 * PER);
        if (!period_end) begin
            checks++;
            errors++;
            $display("FAIL period_end_wait: no pulse in %0d cycles, required one", n);
        end
    endtask

    task automatic wait_commit();
        wait_period_end();
        step();
    endtask

    initial begin
        int w;
        int highs;
        bit acc_now;

        vecs[0] = '{addr: 3'd0, data: 8'h11, exp_err: 1'b0, exp_bus: 32'h4055_8011};
        vecs[1] = '{addr: 3'd6, data: 8'hFF, exp_err: 1'b1, exp_bus: 32'h4055_8011};
        vecs[2] = '{addr: 3'd3, data: 8'hFF, exp_err: 1'b0, exp_bus: 32'hFF55_8011};
        vecs[3] = '{addr: 3'd5, data: 8'h00, exp_err: 1'b1, exp_bus: 32'hFF55_8011};
        vecs[4] = '{addr: 3'd2, data: 8'h00, exp_err: 1'b0, exp_bus: 32'hFF00_8011};
        vecs[5] = '{addr: 3'd7, data: 8'h12, exp_err: 1'b1, exp_bus: 32'hFF00_8011};
        vecs[6] = '{addr: 3'd1, data: 8'h01, exp_err: 1'b0, exp_bus: 32'hFF00_0111};
        vecs[7] = '{addr: 3'd4, data: 8'h00, exp_err: 1'b0, exp_bus: 32'hFF00_0111};

        // Reset state
        rst = 1'b1;
        for (int i = 0; i < 3; i++) step();
        chk("rst wr_ready", 64'(wr_ready), 64'd0);
        chk("rst duty_bus", 64'(duty_bus), 64'd0);
        chk("rst pwm_out", 64'(pwm_out), 64'd0);
        chk("rst wr_err", 64'(wr_err), 64'd0);
        chk("rst period_end", 64'(period_end), 64'd0);
        chk("rst settled", 64'(settled), 64'd1);
        rst = 1'b0;
        step();
        chk("ready after release", 64'(wr_ready), 64'd1);

        // Mid-period write to ch1 only takes effect after the wrap
        while (mk < 100) step();
        do_write(3'd1, 8'h80, w);
        chk("ch1 before wrap", 64'(duty_bus[15:8]), 64'd0);
        wait_period_end();
        chk("ch1 in commit cycle", 64'(duty_bus[15:8]), 64'd0);
        chk("ready in commit", 64'(wr_ready), 64'd0);
        step();
        chk("ch1 after commit", 64'(duty_bus[15:8]), 64'h80);
        for (int i = 0; i < 8; i++) step();
        highs = 0;
        for (int i = 0; i < int'(PER); i++) begin
            step();
            if (pwm_out[1]) highs++;
        end
        chk("ch1 pwm high count", 64'(highs), 64'd256);

        // Write presented on the exact wrap cycle, then a write held across COMMIT
        while (mk % PER != PER - 1) step();
        wr_valid = 1'b1;
        wr_addr  = 3'd2;
        wr_data  = 8'h55;
        chk("ready on wrap cycle", 64'(wr_ready), 64'd1);
        step();
        chk("period_end after wrap", 64'(period_end), 64'd1);
        chk("ready low in commit", 64'(wr_ready), 64'd0);
        do_write(3'd4, 8'h01, w);
        chk("held write wait", 64'(w), 64'd1);
        chk("ch2 same-cycle commit", 64'(duty_bus[23:16]), 64'h55);

        // Soft ramp toward 3, one step per period
        do_write(3'd0, 8'h03, w);
        wait_commit();
        chk("ramp step1", 64'(duty_bus[7:0]), 64'd1);
        chk("ramp step1 settled", 64'(settled), 64'd0);
        wait_commit();
        chk("ramp step2", 64'(duty_bus[7:0]), 64'd2);
        wait_commit();
        chk("ramp step3", 64'(duty_bus[7:0]), 64'd3);
        chk("ramp settled", 64'(settled), 64'd1);

        // HOLD suppresses commits
        do_write(3'd4, 8'h02, w);
        do_write(3'd3, 8'h40, w);
        for (int p = 0; p < 3; p++) begin
            wait_commit();
            chk("hold ch3", 64'(duty_bus[31:24]), 64'd0);
        end
        chk("hold settled", 64'(settled), 64'd0);
        do_write(3'd4, 8'h00, w);
        wait_commit();
        chk("release ch3", 64'(duty_bus[31:24]), 64'h40);

        // Write table, including out-of-range addresses
        foreach (vecs[v]) begin
            do_write(vecs[v].addr, vecs[v].data, w);
            chk($sformatf("vec%0d wr_err", v), 64'(wr_err), 64'(vecs[v].exp_err));
            step();
            chk($sformatf("vec%0d err pulse end", v), 64'(wr_err), 64'd0);
            wait_commit();
            chk($sformatf("vec%0d duty_bus", v), 64'(duty_bus), 64'(vecs[v].exp_bus));
            chk($sformatf("vec%0d settled", v), 64'(settled), 64'd1);
        end

        // Reset during COMMIT aborts the commit
        do_write(3'd1, 8'h10, w);
        wait_period_end();
        rst = 1'b1;
        step();
        chk("rst in commit duty_bus", 64'(duty_bus), 64'd0);
        chk("rst in commit ready", 64'(wr_ready), 64'd0);
        chk("rst in commit settled", 64'(settled), 64'd1);
        chk("rst in commit pwm", 64'(pwm_out), 64'd0);
        rst = 1'b0;
        step();
        chk("ready after second release", 64'(wr_ready), 64'd1);
        chk("duty after second release", 64'(duty_bus), 64'd0);

        // Random traffic against the model
        for (int c = 0; c < 12 * int'(PER); c++) begin
            if (!wr_valid && ($urandom_range(0, 5) == 0)) begin
                wr_valid = 1'b1;
                wr_addr  = 3'($urandom_range(0, 7));
                wr_data  = 8'($urandom_range(0, 255));
            end
            acc_now = wr_valid && wr_ready;
            step();
            if (acc_now) wr_valid = 1'b0;
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
